// File: rtl/matmul_seq_pkg.sv
// matmul_seq_pkg: shared FSM type and fixed-point helpers for matmul_seq.
// Defining MATMUL_SEQ_SAT_EN makes fxp_finalise saturate instead of wrap.
package matmul_seq_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam int MAX_W = 128;

    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n) + 1;
    endfunction

    // Result is consumed by truncation to dw bits at the call site.
    function automatic logic signed [MAX_W-1:0] fxp_finalise(input logic signed [MAX_W-1:0] acc, input int dw);
        logic signed [MAX_W-1:0] hi;
        hi = (MAX_W'(1) << (dw - 1)) - MAX_W'(1);
`ifdef MATMUL_SEQ_SAT_EN
        return acc > hi ? hi : acc < ~hi ? ~hi : acc;
`else
        return acc & ((hi << 1) | MAX_W'(1));
`endif
    endfunction

endpackage

// File: rtl/matmul_seq_mac.sv
// fxp_mac: combinational fixed-point MAC step, acc + ((a * b) >>> BIN_POS).
module fxp_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int BIN_POS    = 8,
    parameter int ACC_W      = 34
) (
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    input  logic signed [ACC_W-1:0]      acc_i,
    output logic signed [ACC_W-1:0]      acc_o
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [2*DATA_WIDTH-1:0] shifted;

    always_comb begin
        prod    = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);
        shifted = prod >>> BIN_POS;
        acc_o   = acc_i + ACC_W'(shifted);
    end

endmodule

// File: rtl/matmul_seq.sv
// matmul_seq: N x N signed fixed-point matrix multiply time-multiplexed over one MAC.
// Define MATMUL_SEQ_SAT_EN to saturate result elements instead of wrapping.
module matmul_seq
    import matmul_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BIN_POS     = 8,
    parameter int MATRIX_SIZE = 2
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   matrix_a,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   matrix_b,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   matrix_c
);

    localparam int N     = MATRIX_SIZE;
    localparam int BW    = N * N * DATA_WIDTH;
    localparam int ACC_W = acc_width(DATA_WIDTH, N);
    localparam int IW    = N > 1 ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_e                  state_q, state_d;
    logic [BW-1:0]           a_q, a_d, b_q, b_d, c_q, c_d;
    logic [IW-1:0]           i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, mac_sum;
    logic signed [DATA_WIDTH-1:0] a_el, b_el;
    logic [DATA_WIDTH-1:0]   c_el;
    logic                    i_last, j_last, k_last;
    int                      a_idx, b_idx, c_idx;

    always_comb begin
        a_idx  = (int'(i_q) * N + int'(k_q)) * DATA_WIDTH;
        b_idx  = (int'(k_q) * N + int'(j_q)) * DATA_WIDTH;
        c_idx  = (int'(i_q) * N + int'(j_q)) * DATA_WIDTH;
        a_el   = a_q[a_idx +: DATA_WIDTH];
        b_el   = b_q[b_idx +: DATA_WIDTH];
        i_last = i_q == LAST;
        j_last = j_q == LAST;
        k_last = k_q == LAST;
    end

    fxp_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .BIN_POS    (BIN_POS),
        .ACC_W      (ACC_W)
    ) u_mac (
        .a_i   (a_el),
        .b_i   (b_el),
        .acc_i (acc_q),
        .acc_o (mac_sum)
    );

    assign c_el = DATA_WIDTH'(fxp_finalise(MAX_W'(mac_sum), DATA_WIDTH));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = matrix_a;
                b_d     = matrix_b;
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
                acc_d   = '0;
                state_d = CALC;
            end
            CALC: if (k_last) begin
                c_d[c_idx +: DATA_WIDTH] = c_el;
                acc_d   = '0;
                k_d     = '0;
                j_d     = j_last ? '0 : j_q + IW'(1);
                i_d     = j_last ? (i_last ? '0 : i_q + IW'(1)) : i_q;
                state_d = (i_last && j_last) ? DONE : CALC;
            end else begin
                k_d   = k_q + IW'(1);
                acc_d = mac_sum;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign matrix_c  = c_q;

endmodule
